box_overlay: RTL and testbench



---
 rtl/box_overlay.sv | 154 +++++++++++++++
 tb/tb_box_overlay.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/box_overlay.sv
// box_overlay
//   Draws a rectangular outline of colour BOX_COLOR around the tracked object
//   in an RGB565 pixel stream. The box geometry is computed from the centroid
//   (px, py) and equal-area side length (a), but is latched only at frame start.
//   This keeps the outline from tearing. When detection is lost, the last box
//   keeps being drawn (coasts) for up to HOLD_FRAMES frames.
//
// Ports
//   clk, rst_n         pixel clock, synchronous active-low reset
//   pre_vs/hs/clken    input frame window / line sync / pixel valid
//   pre_imgdata        input RGB565 pixel
//   px, py, a          tracked centroid and object size (sampled at frame start)
//   post_vs/hs/clken   sync/valid delayed by one cycle
//   post_imgdata       pixel with the overlay applied (one cycle latency)
//   box_valid          a box is being drawn in the current frame
module box_overlay #(
   parameter int          H_ACTIVE    = 800,
   parameter int          V_ACTIVE    = 600,
   parameter logic [15:0] BOX_COLOR   = 16'hF800,
   parameter int          LINE_W      = 2,
   parameter int          MIN_SIZE    = 4,
   parameter int          HOLD_FRAMES = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pre_vs,
   input  logic        pre_hs,
   input  logic        pre_clken,
   input  logic [15:0] pre_imgdata,
   input  logic [10:0] px,
   input  logic [10:0] py,
   input  logic [10:0] a,
   output logic        post_vs,
   output logic        post_hs,
   output logic        post_clken,
   output logic [15:0] post_imgdata,
   output logic        box_valid
);

   typedef enum logic [1:0] {IDLE, TRACK, COAST} state_t;

   localparam logic [10:0] H_MAX = 11'(H_ACTIVE - 1);
   localparam logic [10:0] V_MAX = 11'(V_ACTIVE - 1);
   localparam logic [11:0] LW    = 12'(LINE_W);

   state_t      state;
   logic [7:0]  cnt;
   logic [10:0] x, y;
   logic [10:0] box_l, box_r, box_t, box_b;
   logic        vs_d;
   logic        armed;

   // A frame start needs pre_vs to have been seen low since reset. Without
   // this, a reset in the middle of a frame would see pre_vs high with
   // vs_d cleared and take a spurious frame start, drawing into the rest of
   // a frame that must pass through untouched.
   logic fs;
   assign fs = pre_vs & ~vs_d & armed;

   // Candidate geometry from the current inputs; used only on the fs cycle.
   logic signed [11:0] cx, cy, h, lm, rp, tm, bp;
   logic [9:0]         h_half;
   logic [10:0]        nl, nr, nt, nb;
   logic               v;

   always_comb begin
      cx     = $signed({1'b0, (px > H_MAX) ? H_MAX : px});
      cy     = $signed({1'b0, (py > V_MAX) ? V_MAX : py});
      h_half = (a[10:1] == 10'd0) ? 10'd1 : a[10:1];
      h      = $signed({2'b00, h_half});
      lm     = cx - h;
      rp     = cx + h;
      tm     = cy - h;
      bp     = cy + h;
      nl     = (lm < 0) ? 11'd0 : lm[10:0];
      nt     = (tm < 0) ? 11'd0 : tm[10:0];
      nr     = (rp > $signed({1'b0, H_MAX})) ? H_MAX : rp[10:0];
      nb     = (bp > $signed({1'b0, V_MAX})) ? V_MAX : bp[10:0];
      v      = (a >= 11'(MIN_SIZE));
   end

   // Outline test. The right/bottom bands are written as x+LINE_W > R
   // so that R-LINE_W can never underflow for small boxes.
   logic in_box, in_band, on_outline;
   always_comb begin
      in_box  = (x >= box_l) && (x <= box_r) && (y >= box_t) && (y <= box_b);
      in_band = ({1'b0, x} < {1'b0, box_l} + LW) ||
                ({1'b0, x} + LW > {1'b0, box_r}) ||
                ({1'b0, y} < {1'b0, box_t} + LW) ||
                ({1'b0, y} + LW > {1'b0, box_b});
      on_outline = box_valid && in_box && in_band;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= 8'd0;
         x            <= 11'd0;
         y            <= 11'd0;
         box_l        <= 11'd0;
         box_r        <= 11'd0;
         box_t        <= 11'd0;
         box_b        <= 11'd0;
         vs_d         <= 1'b0;
         armed        <= 1'b0;
         post_vs      <= 1'b0;
         post_hs      <= 1'b0;
         post_clken   <= 1'b0;
         post_imgdata <= 16'd0;
         box_valid    <= 1'b0;
      end else begin
         vs_d       <= pre_vs;
         armed      <= armed | ~pre_vs;
         post_vs    <= pre_vs;
         post_hs    <= pre_hs;
         post_clken <= pre_clken;
         post_imgdata <= (pre_clken && on_outline) ? BOX_COLOR : pre_imgdata;

         // Counters; fs has priority over any wrap.
         if (fs) begin
            x <= 11'd0;
            y <= 11'd0;
         end else if (pre_clken) begin
            if (x == H_MAX) begin
               x <= 11'd0;
               y <= (y == V_MAX) ? 11'd0 : y + 11'd1;
            end else begin
               x <= x + 11'd1;
            end
         end

         // Box state only ever changes at frame start.
         if (fs) begin
            if (v) begin
               state     <= TRACK;
               cnt       <= 8'(HOLD_FRAMES);
               box_l     <= nl;
               box_r     <= nr;
               box_t     <= nt;
               box_b     <= nb;
               box_valid <= 1'b1;
            end else if (state != IDLE && cnt != 8'd0) begin
               state     <= COAST;
               cnt       <= cnt - 8'd1;
               box_valid <= 1'b1;
            end else begin
               state     <= IDLE;
               box_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_box_overlay.sv
// tb_box_overlay
//   Randomised stimulus against a frame-level behavioural model of the box
//   overlay. A reduced frame size keeps whole frames short. Every output
//   cycle is compared, and literal pixel and box checks pin the model.
module tb_box_overlay;
   localparam int          H    = 40;
   localparam int          V    = 30;
   localparam int          LW   = 2;
   localparam int          MINS = 4;
   localparam int          HOLD = 8;
   localparam logic [15:0] COL  = 16'hF800;
   localparam logic [15:0] FIX  = 16'h1234;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pre_vs = 1'b0, pre_hs = 1'b0, pre_clken = 1'b0;
   logic [15:0] pre_imgdata = 16'd0;
   logic [10:0] px = 11'd0, py = 11'd0, a = 11'd0;
   logic        post_vs, post_hs, post_clken, box_valid;
   logic [15:0] post_imgdata;

   always #5 clk = ~clk;

   box_overlay #(.H_ACTIVE(H), .V_ACTIVE(V), .BOX_COLOR(COL), .LINE_W(LW),
                 .MIN_SIZE(MINS), .HOLD_FRAMES(HOLD)) dut (
      .clk(clk), .rst_n(rst_n), .pre_vs(pre_vs), .pre_hs(pre_hs),
      .pre_clken(pre_clken), .pre_imgdata(pre_imgdata), .px(px), .py(py), .a(a),
      .post_vs(post_vs), .post_hs(post_hs), .post_clken(post_clken),
      .post_imgdata(post_imgdata), .box_valid(box_valid));

   typedef struct {
      logic [19:0] o;   // {vs, hs, clken, data, box_valid}
      bit          grab;
      int          x, y;
   } exp_t;

   exp_t q[$];
   int   checks = 0, failures = 0;
   logic [15:0] grab_img [H*V];

   // Frame-level model: box corners, drawing flag and remaining coast frames.
   bit m_valid, m_armed, m_pvs;
   int m_cnt, mL, mR, mT, mB;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   function automatic bit on_box(input int x, input int y);
      return m_valid && x >= mL && x <= mR && y >= mT && y <= mB &&
             (x < mL + LW || x > mR - LW || y < mT + LW || y > mB - LW);
   endfunction

   task automatic model_frame_start();
      int cx, cy, h;
      cx = (int'(px) > H - 1) ? H - 1 : int'(px);
      cy = (int'(py) > V - 1) ? V - 1 : int'(py);
      h  = int'(a) / 2;
      if (h < 1) h = 1;
      if (int'(a) >= MINS) begin
         m_valid = 1; m_cnt = HOLD;
         mL = (cx - h < 0) ? 0 : cx - h;
         mR = (cx + h > H - 1) ? H - 1 : cx + h;
         mT = (cy - h < 0) ? 0 : cy - h;
         mB = (cy + h > V - 1) ? V - 1 : cy + h;
      end else if (m_valid) begin
         if (m_cnt > 0) m_cnt--;
         else m_valid = 0;
      end
   endtask

   // Drive one cycle, record what the outputs must be after the next edge.
   task automatic cyc(input bit rn, input bit vs, input bit ce,
                      input int x, input int y, input bit grab, input bit fixed_pix);
      exp_t e;
      bit   fs;
      rst_n = rn; pre_vs = vs; pre_clken = ce; pre_hs = 1'($urandom);
      pre_imgdata = fixed_pix ? FIX : 16'($urandom);
      e.grab = grab; e.x = x; e.y = y;
      if (!rn) begin
         e.o = 20'd0;
         m_valid = 0; m_cnt = 0; m_armed = 0; m_pvs = 0;
      end else begin
         e.o[19]   = vs;
         e.o[18]   = pre_hs;
         e.o[17]   = ce;
         e.o[16:1] = (ce && on_box(x, y)) ? COL : pre_imgdata;
         fs = vs && !m_pvs && m_armed;
         m_pvs = vs;
         if (!vs) m_armed = 1;
         if (fs) model_frame_start();
         e.o[0] = m_valid;
      end
      q.push_back(e);
      @(posedge clk); #2;
   endtask

   // One frame: short vblank, fs cycle with the given inputs, then all pixels
   // with occasional idle gaps. rnd scrambles px/py/a after fs, chg_px moves
   // px mid-frame, rst_at pulses reset at that pixel index.
   task automatic frame(input int fpx, input int fpy, input int fa, input bit grab,
                        input bit rnd, input int chg_px, input int rst_at);
      int nb;
      nb = 2 + $urandom_range(0, 3);
      for (int i = 0; i < nb; i++) cyc(1, 0, 0, 0, 0, 0, grab);
      px = 11'(fpx); py = 11'(fpy); a = 11'(fa);
      cyc(1, 1, 0, 0, 0, 0, grab);
      for (int yy = 0; yy < V; yy++) begin
         for (int xx = 0; xx < H; xx++) begin
            if ($urandom_range(0, 7) == 0) cyc(1, 1, 0, xx, yy, 0, grab);
            if (rnd) begin
               px = 11'($urandom_range(0, 2047));
               py = 11'($urandom_range(0, 2047));
               a  = 11'($urandom_range(0, 2047));
            end
            if (chg_px >= 0 && yy == V / 2) px = 11'(chg_px);
            cyc((yy * H + xx) != rst_at, 1, 1, xx, yy, grab, grab);
         end
      end
   endtask

   function automatic int pix(input int x, input int y);
      return y * H + x;
   endfunction

   // Compare process: every cycle that has an expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk); #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk($sformatf("post(%0d,%0d)", e.x, e.y),
                32'({post_vs, post_hs, post_clken, post_imgdata, box_valid}), 32'(e.o));
            if (e.grab && e.o[17]) grab_img[pix(e.x, e.y)] = post_imgdata;
         end
      end
   end

   initial begin
      @(posedge clk); #2;
      for (int i = 0; i < 3; i++) cyc(0, 1'($urandom), 1'($urandom), 0, 0, 0, 0);

      // Passthrough in IDLE with random streams.
      for (int f = 0; f < 2; f++) frame($urandom_range(0, 60), $urandom_range(0, 60),
                                        $urandom_range(0, 3), 0, 1, -1, -1);
      chk("idle_bv", 32'(box_valid), 32'd0);

      // Centred box: L=16 R=24 T=11 B=19.
      frame(20, 15, 8, 1, 0, -1, -1);
      chk("ctr_L", mL, 16); chk("ctr_R", mR, 24); chk("ctr_T", mT, 11); chk("ctr_B", mB, 19);
      chk("ctr_bv", 32'(box_valid), 32'd1);
      chk("ctr_16_15", 32'(grab_img[pix(16, 15)]), 32'(COL));
      chk("ctr_17_15", 32'(grab_img[pix(17, 15)]), 32'(COL));
      chk("ctr_20_11", 32'(grab_img[pix(20, 11)]), 32'(COL));
      chk("ctr_24_19", 32'(grab_img[pix(24, 19)]), 32'(COL));
      chk("ctr_18_15", 32'(grab_img[pix(18, 15)]), 32'(FIX));
      chk("ctr_20_15", 32'(grab_img[pix(20, 15)]), 32'(FIX));
      chk("ctr_15_15", 32'(grab_img[pix(15, 15)]), 32'(FIX));

      // Edge clamp: L=0 T=0 R=6 B=6.
      frame(2, 2, 8, 1, 0, -1, -1);
      chk("edge_L", mL, 0); chk("edge_R", mR, 6);
      chk("edge_0_4", 32'(grab_img[pix(0, 4)]), 32'(COL));
      chk("edge_4_0", 32'(grab_img[pix(4, 0)]), 32'(COL));
      chk("edge_39_4", 32'(grab_img[pix(H - 1, 4)]), 32'(FIX));
      chk("edge_7_4", 32'(grab_img[pix(7, 4)]), 32'(FIX));

      // Coast for HOLD frames, then drop.
      frame(20, 15, 8, 0, 0, -1, -1);
      for (int k = 1; k <= HOLD + 1; k++) begin
         frame(20, 15, 2, 0, 0, -1, -1);
         chk($sformatf("coast_bv%0d", k), 32'(box_valid), (k <= HOLD) ? 32'd1 : 32'd0);
      end
      // Reload mid-coast.
      frame(20, 15, 8, 0, 0, -1, -1);
      frame(20, 15, 2, 0, 0, -1, -1);
      frame(20, 15, 2, 0, 0, -1, -1);
      frame(10, 10, 8, 0, 0, -1, -1);
      chk("reload_L", mL, 6);
      chk("reload_bv", 32'(box_valid), 32'd1);

      // Mid-frame px change is ignored until the next fs.
      frame(20, 15, 8, 1, 0, 5, -1);
      chk("chg_16_15", 32'(grab_img[pix(16, 15)]), 32'(COL));
      frame(5, 15, 8, 1, 0, -1, -1);
      chk("chg_next_1_15", 32'(grab_img[pix(1, 15)]), 32'(COL));
      chk("chg_next_16_15", 32'(grab_img[pix(16, 15)]), 32'(FIX));

      // Reset mid-frame while tracking.
      frame(20, 15, 8, 0, 0, -1, -1);
      frame(20, 15, 8, 0, 0, -1, pix(30, 20));
      chk("rst_bv", 32'(box_valid), 32'd0);
      frame(20, 15, 8, 1, 0, -1, -1);
      chk("rst_next_16_15", 32'(grab_img[pix(16, 15)]), 32'(COL));
      chk("rst_next_18_15", 32'(grab_img[pix(18, 15)]), 32'(FIX));

      // Random frames.
      for (int f = 0; f < 6; f++)
         frame(($urandom_range(0, 4) == 0) ? 2047 : $urandom_range(0, 50),
               $urandom_range(0, 40),
               ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 30),
               0, 1, -1, -1);

      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #3;
      chk("drain", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
